// File: rtl/bht_resolve_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bht_resolve_queue                                            |
// | Description : In-order queue of predicted branches awaiting resolution;    |
// |               emits BHT training updates and counts mispredictions.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bht_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       flush,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           mispred_count
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};
    localparam logic [c_AW:0]     c_OCC_ONE = {{c_AW{1'b0}}, 1'b1};
    localparam logic [c_AW:0]     c_OCC_MAX = DEPTH[c_AW:0];
    localparam logic [CNT_W-1:0]  c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

    logic [PC_W-1:0]  r_mem_pc   [DEPTH];
    logic             r_mem_pred [DEPTH];
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_AW:0]    r_occ;

    logic             w_pop;
    logic             w_mis;
    logic             w_clear;
    logic             w_push;
    logic [c_AW:0]    w_occ_next;

    assign pred_ready = (r_occ < c_OCC_MAX);
    assign occupancy  = r_occ;

    // A mispredicting resolve squashes younger entries exactly like a flush,
    // and either one drops whatever fetch offers in the same cycle.
    assign w_pop   = res_valid && (r_occ != '0);
    assign w_mis   = w_pop && (res_taken != r_mem_pred[r_head]);
    assign w_clear = w_mis || flush;
    assign w_push  = pred_valid && pred_ready && !w_clear;

    always_comb begin
        w_occ_next = r_occ;
        if (w_clear) begin
            w_occ_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_occ_next = r_occ + c_OCC_ONE;
                2'b01:   w_occ_next = r_occ - c_OCC_ONE;
                default: w_occ_next = r_occ;
            endcase
        end
    end

    // Payload storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]   <= pred_pc;
            r_mem_pred[r_tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_clear) begin
                r_head <= r_tail;
            end else begin
                if (w_pop)  r_head <= r_head + c_PTR_ONE;
                if (w_push) r_tail <= r_tail + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid     <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            res_err       <= 1'b0;
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            upd_valid  <= w_pop;
            mispredict <= w_mis;
            res_err    <= res_valid && (r_occ == '0);
            if (w_pop) begin
                upd_pc    <= r_mem_pc[r_head];
                upd_taken <= res_taken;
                if (branch_count != c_CNT_MAX) branch_count <= branch_count + c_CNT_ONE;
            end
            if (w_mis && (mispred_count != c_CNT_MAX)) begin
                mispred_count <= mispred_count + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_resolve_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bht_resolve_queue                                         |
// | Description : Directed self-checking bench for bht_resolve_queue.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bht_resolve_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [8:0]  pred_pc;
    logic        pred_taken;
    logic        pred_ready;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        upd_valid;
    logic [8:0]  upd_pc;
    logic        upd_taken;
    logic        mispredict;
    logic        res_err;
    logic [2:0]  occupancy;
    logic [15:0] branch_count;
    logic [15:0] mispred_count;

    int n_cmp  = 0;
    int n_fail = 0;

    bht_resolve_queue #(.DEPTH(4), .PC_W(9), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .res_err(res_err), .occupancy(occupancy),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [8:0] pc, input logic pt);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = pt;
        step();
        pred_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_cmp++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pred_ready); end
        n_cmp++; if ({upd_valid, mispredict, res_err, upd_taken} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {upd_valid, mispredict, res_err, upd_taken}); end
        n_cmp++; if (upd_pc !== 9'h000) begin n_fail++; $display("FAIL reset_upd_pc: got %h want 000", upd_pc); end
        n_cmp++; if ({branch_count, mispred_count} !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %h want 0", {branch_count, mispred_count}); end
    endtask

    task automatic test_single();
        enqueue(9'h010, 1'b1);
        n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL single_occ: got %0d want 1", occupancy); end
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        n_cmp++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL single_upd_valid: got %b want 1", upd_valid); end
        n_cmp++; if (upd_pc !== 9'h010) begin n_fail++; $display("FAIL single_upd_pc: got %h want 010", upd_pc); end
        n_cmp++; if ({upd_taken, mispredict} !== 2'b10) begin n_fail++; $display("FAIL single_taken_mis: got %b want 10", {upd_taken, mispredict}); end
        n_cmp++; if (branch_count !== 16'd1) begin n_fail++; $display("FAIL single_bcount: got %0d want 1", branch_count); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL single_occ_after: got %0d want 0", occupancy); end
        step();
        n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b want 0", upd_valid); end
        n_cmp++; if (upd_pc !== 9'h010) begin n_fail++; $display("FAIL single_hold_pc: got %h want 010", upd_pc); end
    endtask

    task automatic test_fill_drain();
        logic [8:0] pcs [4] = '{9'h100, 9'h101, 9'h102, 9'h103};
        for (int i = 0; i < 4; i++) enqueue(pcs[i], 1'b1);
        n_cmp++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", pred_ready); end
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d want 4", occupancy); end
        enqueue(9'h1FF, 1'b0);
        n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_overflow_occ: got %0d want 4", occupancy); end
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1; res_taken = 1'b1;
            step();
            res_valid = 1'b0;
            n_cmp++; if (upd_valid !== 1'b1 || upd_pc !== pcs[i]) begin n_fail++; $display("FAIL drain_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, upd_valid, upd_pc, pcs[i]); end
            n_cmp++; if (occupancy !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_occ[%0d]: got %0d want %0d", i, occupancy, 3 - i); end
        end
        n_cmp++; if ({branch_count, mispred_count} !== {16'd5, 16'd0}) begin n_fail++; $display("FAIL drain_counts: got %0d/%0d want 5/0", branch_count, mispred_count); end
        step();
        n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_no_extra: got %b want 0", upd_valid); end
    endtask

    task automatic test_mispredict();
        enqueue(9'h020, 1'b0);
        enqueue(9'h021, 1'b1);
        res_valid = 1'b1; res_taken = 1'b1;
        pred_valid = 1'b1; pred_pc = 9'h022; pred_taken = 1'b1;
        step();
        res_valid = 1'b0; pred_valid = 1'b0;
        n_cmp++; if ({upd_valid, mispredict, upd_taken} !== 3'b111) begin n_fail++; $display("FAIL mis_flags: got %b want 111", {upd_valid, mispredict, upd_taken}); end
        n_cmp++; if (upd_pc !== 9'h020) begin n_fail++; $display("FAIL mis_pc: got %h want 020", upd_pc); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL mis_occ: got %0d want 0", occupancy); end
        n_cmp++; if ({branch_count, mispred_count} !== {16'd6, 16'd1}) begin n_fail++; $display("FAIL mis_counts: got %0d/%0d want 6/1", branch_count, mispred_count); end
        step();
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", mispredict); end
    endtask

    task automatic test_empty_resolve();
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        n_cmp++; if ({res_err, upd_valid, mispredict} !== 3'b100) begin n_fail++; $display("FAIL empty_flags: got %b want 100", {res_err, upd_valid, mispredict}); end
        n_cmp++; if ({branch_count, mispred_count} !== {16'd6, 16'd1}) begin n_fail++; $display("FAIL empty_counts: got %0d/%0d want 6/1", branch_count, mispred_count); end
        n_cmp++; if (upd_pc !== 9'h020) begin n_fail++; $display("FAIL empty_hold_pc: got %h want 020", upd_pc); end
        step();
        n_cmp++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL empty_pulse: got %b want 0", res_err); end
    endtask

    task automatic test_flush_resolve();
        enqueue(9'h030, 1'b0);
        enqueue(9'h031, 1'b1);
        enqueue(9'h032, 1'b0);
        n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
        res_valid = 1'b1; res_taken = 1'b0; flush = 1'b1;
        pred_valid = 1'b1; pred_pc = 9'h033; pred_taken = 1'b0;
        step();
        res_valid = 1'b0; flush = 1'b0; pred_valid = 1'b0;
        n_cmp++; if ({upd_valid, mispredict, upd_taken} !== 3'b100) begin n_fail++; $display("FAIL flush_flags: got %b want 100", {upd_valid, mispredict, upd_taken}); end
        n_cmp++; if (upd_pc !== 9'h030) begin n_fail++; $display("FAIL flush_pc: got %h want 030", upd_pc); end
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        n_cmp++; if ({branch_count, mispred_count} !== {16'd7, 16'd1}) begin n_fail++; $display("FAIL flush_counts: got %0d/%0d want 7/1", branch_count, mispred_count); end
        step();
        n_cmp++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_single_update: got %b want 0", upd_valid); end
    endtask

    task automatic test_reset_mid();
        enqueue(9'h040, 1'b1);
        enqueue(9'h041, 1'b1);
        enqueue(9'h042, 1'b1);
        res_valid = 1'b1; res_taken = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (occupancy !== 3'd0 || pred_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_occ: got occ=%0d rdy=%b want 0/1", occupancy, pred_ready); end
        n_cmp++; if ({branch_count, mispred_count} !== 32'h0) begin n_fail++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", branch_count, mispred_count); end
        n_cmp++; if (upd_pc !== 9'h000) begin n_fail++; $display("FAIL rstmid_pc: got %h want 000", upd_pc); end
        step();
        n_cmp++; if ({upd_valid, mispredict, res_err} !== 3'b000) begin n_fail++; $display("FAIL rstmid_no_update: got %b want 000", {upd_valid, mispredict, res_err}); end
        res_valid = 1'b0;
        reset = 1'b0;
        step();
        n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rstmid_release_occ: got %0d want 0", occupancy); end
        // Queue must be usable again after the mid-operation reset.
        enqueue(9'h050, 1'b1);
        res_valid = 1'b1; res_taken = 1'b0;
        step();
        res_valid = 1'b0;
        n_cmp++; if ({upd_valid, mispredict, upd_taken} !== 3'b110 || upd_pc !== 9'h050) begin n_fail++; $display("FAIL post_rst: got %b pc=%h want 110 pc=050", {upd_valid, mispredict, upd_taken}, upd_pc); end
        n_cmp++; if ({branch_count, mispred_count} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL post_rst_counts: got %0d/%0d want 1/1", branch_count, mispred_count); end
    endtask

    initial begin
        reset = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
        res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0;
        step();
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_single();
        test_fill_drain();
        test_mispredict();
        test_empty_resolve();
        test_flush_resolve();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
